// File: rtl/uart_cmd_initiator.sv
// Host-side initiator for the UART register-access protocol: sends opcode/addr/data
// command frames and validates the echoed response. Optional macro: CMD_CHECKSUM_EN.
module uart_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  OP_WRITE       = 8'h01,
  parameter logic [7:0]  OP_READ        = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEND_OP   = 4'd1,
    SEND_ADDR = 4'd2,
    SEND_DATA = 4'd3,
`ifdef CMD_CHECKSUM_EN
    SEND_CSUM = 4'd4,
    WAIT_CSUM = 4'd8,
`endif
    WAIT_OP   = 4'd5,
    WAIT_ADDR = 4'd6,
    WAIT_DATA = 4'd7,
    DONE      = 4'd9
  } state_t;

  state_t        state_q;
  logic          req_ready_q, tx_valid_q, rsp_valid_q, busy_q, mis_q;
  logic [7:0]    tx_data_q, rsp_rdata_q, op_q, addr_q, data_q;
  logic [1:0]    rsp_err_q;
  logic [CW-1:0] to_cnt_q;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    rx_x_q, rx_data_q;
`endif

  logic tx_hs_s, in_wait_s, timeout_s;

  assign tx_hs_s = tx_valid_q & tx_ready;
`ifdef CMD_CHECKSUM_EN
  assign in_wait_s = (state_q == WAIT_OP) || (state_q == WAIT_ADDR) ||
                     (state_q == WAIT_DATA) || (state_q == WAIT_CSUM);
`else
  assign in_wait_s = (state_q == WAIT_OP) || (state_q == WAIT_ADDR) || (state_q == WAIT_DATA);
`endif
  // A byte arriving on the final counted cycle takes priority over the timeout.
  assign timeout_s = in_wait_s & ~rx_valid & (to_cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 2'b00;
      busy_q      <= 1'b0;
      to_cnt_q    <= '0;
      op_q        <= 8'h00;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      mis_q       <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      rx_x_q      <= 8'h00;
      rx_data_q   <= 8'h00;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      if (in_wait_s) to_cnt_q <= rx_valid ? '0 : to_cnt_q + CW'(1);
      if (timeout_s) begin
        state_q     <= DONE;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 2'b01;
      end else begin
        case (state_q)
          IDLE: if (req_valid && req_ready_q) begin
            op_q        <= req_write ? OP_WRITE : OP_READ;
            addr_q      <= req_addr;
            data_q      <= req_write ? req_wdata : 8'h00;
            tx_data_q   <= req_write ? OP_WRITE : OP_READ;
            tx_valid_q  <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            mis_q       <= 1'b0;
            state_q     <= SEND_OP;
          end
          SEND_OP: if (tx_hs_s) begin
            tx_data_q <= addr_q;
            state_q   <= SEND_ADDR;
          end
          SEND_ADDR: if (tx_hs_s) begin
            tx_data_q <= data_q;
            state_q   <= SEND_DATA;
          end
`ifdef CMD_CHECKSUM_EN
          SEND_DATA: if (tx_hs_s) begin
            tx_data_q <= op_q ^ addr_q ^ data_q;
            state_q   <= SEND_CSUM;
          end
          SEND_CSUM: if (tx_hs_s) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            to_cnt_q   <= '0;
            state_q    <= WAIT_OP;
          end
`else
          SEND_DATA: if (tx_hs_s) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            to_cnt_q   <= '0;
            state_q    <= WAIT_OP;
          end
`endif
          WAIT_OP: if (rx_valid) begin
            mis_q   <= mis_q | (rx_data != op_q);
`ifdef CMD_CHECKSUM_EN
            rx_x_q  <= rx_data;
`endif
            state_q <= WAIT_ADDR;
          end
          WAIT_ADDR: if (rx_valid) begin
            mis_q   <= mis_q | (rx_data != addr_q);
`ifdef CMD_CHECKSUM_EN
            rx_x_q  <= rx_x_q ^ rx_data;
`endif
            state_q <= WAIT_DATA;
          end
`ifdef CMD_CHECKSUM_EN
          WAIT_DATA: if (rx_valid) begin
            rx_data_q <= rx_data;
            rx_x_q    <= rx_x_q ^ rx_data;
            state_q   <= WAIT_CSUM;
          end
          WAIT_CSUM: if (rx_valid) begin
            rsp_rdata_q <= rx_data_q;
            rsp_err_q   <= (rx_data != rx_x_q) ? 2'b11 : (mis_q ? 2'b10 : 2'b00);
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
`else
          WAIT_DATA: if (rx_valid) begin
            rsp_rdata_q <= rx_data;
            rsp_err_q   <= mis_q ? 2'b10 : 2'b00;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
`endif
          DONE: begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
          default: begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            state_q     <= IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready = req_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
Host-side initiator for the UART register-access protocol. Accepts one read/write request at a time and serializes it into a command byte frame for a byte-level UART transmitter. It then collects the byte frame returned by the target, validates it, and reports read data or an error. Used in the system bench and as an on-chip loopback master that drives the register-access path from the other end of the link.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed from last command byte accepted to each response byte before a timeout error.
OP_WRITE, 8'h01, opcode byte for a write command.
OP_READ, 8'h02, opcode byte for a read command.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block idle; request accepted when req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_addr  in  8  register address
req_wdata  in  8  write data; ignored for reads, which send 8'h00
tx_data  out  8  command byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready
rx_data  in  8  response byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  response data byte; held until next completion
rsp_err  out  2  00 ok, 01 timeout, 10 opcode/address mismatch, 11 checksum error
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high): state = IDLE; req_ready = 1; tx_valid = 0; tx_data = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; busy = 0; timeout counter = 0. Reset mid-frame aborts the frame with no rsp_valid pulse.
- On accept, register write, addr and wdata (or 8'h00 for reads). Set opcode to OP_WRITE or OP_READ. req_ready drops on the next cycle.
- Command frame bytes, in order: opcode, addr, data. One byte is presented per state.
- tx_valid is high in the send states. tx_data is stable until the handshake completes, and the state advances on tx_valid & tx_ready.
- States:
  - IDLE -> SEND_OP on accept.
  - SEND_OP -> SEND_ADDR -> SEND_DATA, each on handshake.
  - SEND_DATA -> WAIT_OP on handshake.
  - WAIT_OP -> WAIT_ADDR -> WAIT_DATA, each on rx_valid.
  - WAIT_DATA -> DONE on rx_valid.
  - DONE -> IDLE after 1 cycle.
- Response frame bytes, in order: opcode echo, addr echo, data. Write responses echo the written data; read responses carry the read data.
- rx_valid outside the WAIT states is ignored, with no state change.
- Timeout counter:
  - Clears on entry to WAIT_OP and on every rx_valid in a WAIT state.
  - Increments each cycle in a WAIT state.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: go to DONE with rsp_err = 01 and rsp_rdata unchanged.
  - If rx_valid arrives on that same cycle, the byte wins.
- Mismatch: an opcode or addr echo that differs from the registered value sets a sticky mismatch flag. Reception continues to the end of the frame, then DONE reports rsp_err = 10. rsp_rdata is still loaded with the received data byte.
- DONE: rsp_valid = 1 for exactly one cycle. rsp_rdata/rsp_err update in the same cycle. req_ready returns the cycle after DONE.
- Back-to-back: a request held on req_valid is accepted on the first IDLE cycle. This gives a 1-cycle gap after rsp_valid.
- Error priority when several apply: timeout > checksum > mismatch.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- Defined:
  - A fourth command byte is sent after data (state SEND_CSUM): opcode ^ addr ^ data.
  - A fourth response byte is expected (state WAIT_CSUM) and compared against the XOR of the three received bytes.
  - An unequal checksum gives rsp_err = 11.
- Undefined: 3-byte frames, the CSUM states do not exist, and rsp_err never equals 11.

Test Plan:
- Write addr 0x10 data 0x5A with tx_ready held 1; feed response 01,10,5A -> tx bytes 01,10,5A; rsp_valid one cycle, rsp_err=00, rsp_rdata=5A.
- Read addr 0x22; tx_ready low for 3 cycles on each byte; respond 02,22,C3 -> tx_data stable while stalled; bytes 02,22,00; rsp_rdata=C3, err=00.
- Read addr 0x05; no response; TIMEOUT_CYCLES=50 -> rsp_valid exactly 50 cycles after last tx handshake, err=01, rsp_rdata keeps previous value; with one byte at cycle 30, the timeout occurs 50 cycles after that byte instead.
- Read addr 0x07; respond 02,08,11 -> err=10 after the third byte, rsp_rdata=11.
- Assert rst during WAIT_ADDR, then issue a write to 0x01 -> no rsp_valid from the aborted frame; the new frame completes normally, err=00.
- With CMD_CHECKSUM_EN, write 0x10/0x5A -> 4th tx byte 0x4B; a response with checksum 0x4B gives err=00; a response with checksum 0x00 gives err=11.
